// File: rtl/cnn_pkg.sv
// Types and constants shared between the window generator and the conv stage.
// The window layout is row-major, so index 0 is top-left and index 8 is bottom-right.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int KERNEL_SIZE    = 3;
    localparam int WIN_ELEMS      = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic signed [DATA_WIDTH_DEF-1:0] pixel_t;
    typedef pixel_t [WIN_ELEMS-1:0]           window_t;

    // Flat window index for kernel position (r, c); this matches the conv weight index.
    function automatic int win_idx(input int r, input int c);
        return r * KERNEL_SIZE + c;
    endfunction

endpackage

// File: rtl/cnn_line_buf.sv
// Single-port row delay line. The caller supplies the column as the address,
// so a read returns the value that was written at this column one row earlier.
module cnn_line_buf
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 28,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    // Contents are left unreset: every entry is rewritten before it can reach a valid window.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign dout_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// Turns a raster pixel stream into 3x3 valid-convolution windows. A handshake on
// both sides means a stalled window blocks further pixels.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 pix_valid_i,
    output logic                                 pix_ready_o,
    input  logic signed [DATA_WIDTH-1:0]         pix_data_i,
    output logic                                 win_valid_o,
    input  logic                                 win_ready_i,
    output logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] window_o,
    output logic                                 frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]                        col_q, col_d;
    logic [RW-1:0]                        row_q, row_d;
    logic                                 win_valid_q, win_valid_d;
    logic                                 frame_done_q, frame_done_d;
    logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_q, win_d;

    logic                  xfer;
    logic                  last_col, last_row;
    logic                  completing;
    logic [DATA_WIDTH-1:0] row1_pix, row2_pix;

    assign pix_ready_o = !win_valid_q || win_ready_i;
    assign xfer        = pix_valid_i && pix_ready_o;
    assign last_col    = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row    = (row_q == RW'(IMG_HEIGHT - 1));
    assign completing  = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // lb1 holds the row above; lb2 is fed from lb1 and therefore holds two rows up.
    cnn_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk_i  (clk_i),
        .we_i   (xfer),
        .addr_i (col_q),
        .din_i  (pix_data_i),
        .dout_o (row1_pix)
    );

    cnn_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb2 (
        .clk_i  (clk_i),
        .we_i   (xfer),
        .addr_i (col_q),
        .din_i  (row1_pix),
        .dout_o (row2_pix)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (xfer) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // Shift every kernel row one column left and load the new column on the right.
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
                end
            end
            win_d[win_idx(0, KERNEL_SIZE - 1)] = row2_pix;
            win_d[win_idx(1, KERNEL_SIZE - 1)] = row1_pix;
            win_d[win_idx(2, KERNEL_SIZE - 1)] = pix_data_i;

            win_valid_d  = completing;
            frame_done_d = last_col && last_row;
        end else if (win_ready_i) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid_o  = win_valid_q;
    assign window_o     = win_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for the window generator: 4x4 frames, a 5x3 signed frame and
// random-handshake 28x28 frames checked against a window model.
module tb_cnn_window_gen;
    import cnn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] w3(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        logic [71:0] r;
        logic [7:0]  b [9];
        b[0] = a0[7:0]; b[1] = a1[7:0]; b[2] = a2[7:0];
        b[3] = a3[7:0]; b[4] = a4[7:0]; b[5] = a5[7:0];
        b[6] = a6[7:0]; b[7] = a7[7:0]; b[8] = a8[7:0];
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = b[i];
        return r;
    endfunction

    // Window of a 4-wide frame whose top-left pixel has value b (pixels numbered in raster order).
    function automatic logic [71:0] win4(input int b);
        return w3(b, b+1, b+2, b+4, b+5, b+6, b+8, b+9, b+10);
    endfunction

    // ---------------- DUT A: 4x4 ----------------
    logic              a_rst = 1'b1, a_pv = 1'b0, a_wr = 1'b1;
    logic [7:0]        a_pd  = '0;
    logic              a_pr, a_wv, a_fd;
    logic [8:0][7:0]   a_win;
    int                a_mode = 0;
    int                a_sc = 0;

    cnn_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
        .clk_i(clk), .rst_i(a_rst), .pix_valid_i(a_pv), .pix_ready_o(a_pr),
        .pix_data_i(a_pd), .win_valid_o(a_wv), .win_ready_i(a_wr),
        .window_o(a_win), .frame_done_o(a_fd)
    );

    // ---------------- DUT B: 5 wide, 3 high ----------------
    logic              b_rst = 1'b1, b_pv = 1'b0, b_wr = 1'b1;
    logic [7:0]        b_pd  = '0;
    logic              b_pr, b_wv, b_fd;
    logic [8:0][7:0]   b_win;

    cnn_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_b (
        .clk_i(clk), .rst_i(b_rst), .pix_valid_i(b_pv), .pix_ready_o(b_pr),
        .pix_data_i(b_pd), .win_valid_o(b_wv), .win_ready_i(b_wr),
        .window_o(b_win), .frame_done_o(b_fd)
    );

    // ---------------- DUT C: 28x28 ----------------
    logic              c_rst = 1'b1, c_pv = 1'b0, c_wr = 1'b1;
    logic [7:0]        c_pd  = '0;
    logic              c_pr, c_wv, c_fd;
    logic [8:0][7:0]   c_win;
    logic              c_rnd = 1'b0;

    cnn_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u_c (
        .clk_i(clk), .rst_i(c_rst), .pix_valid_i(c_pv), .pix_ready_o(c_pr),
        .pix_data_i(c_pd), .win_valid_o(c_wv), .win_ready_i(c_wr),
        .window_o(c_win), .frame_done_o(c_fd)
    );

    // Downstream ready policies, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (a_mode == 1) begin
            if (a_wv) begin
                if (a_sc < 3) begin a_wr = 1'b0; a_sc++; end
                else          begin a_wr = 1'b1; a_sc = 0; end
            end else begin
                a_wr = 1'b0; a_sc = 0;
            end
        end else begin
            a_wr = 1'b1;
        end
        c_wr = c_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitors sample on the falling edge, when inputs and outputs are settled.
    logic [71:0] qa[$], qb[$], qc[$];
    int          a_pidx = 0, a_fd_cnt = 0, b_fd_cnt = 0, c_fd_cnt = 0;
    logic        a_fd_exp = 1'b0, a_stalled = 1'b0;
    logic [71:0] a_win_prev;

    always @(negedge clk) begin
        if (a_rst) begin
            a_pidx = 0; a_fd_exp = 1'b0; a_stalled = 1'b0;
        end else begin
            chk("a_frame_done", {71'd0, a_fd}, {71'd0, a_fd_exp});
            if (a_fd) a_fd_cnt++;
            if (a_wv && !a_wr) begin
                chk("a_stall_pix_ready", {71'd0, a_pr}, 72'd0);
                if (a_stalled) chk("a_stall_hold", a_win, a_win_prev);
            end
            a_stalled  = a_wv && !a_wr;
            a_win_prev = a_win;
            if (a_wv && a_wr) qa.push_back(a_win);
            a_fd_exp = a_pv && a_pr && (a_pidx == 15);
            if (a_pv && a_pr) a_pidx = (a_pidx + 1) % 16;
        end
        if (!b_rst) begin
            if (b_wv && b_wr) qb.push_back(b_win);
            if (b_fd) b_fd_cnt++;
        end
        if (!c_rst) begin
            if (c_wv && c_wr) qc.push_back(c_win);
            if (c_fd) c_fd_cnt++;
        end
    end

    task automatic send_a(input logic [7:0] v);
        logic ok; int g;
        ok = 1'b0; g = 0;
        a_pv = 1'b1; a_pd = v;
        while (!ok && g < 64) begin
            @(negedge clk); ok = a_pr;
            @(posedge clk); #1; g++;
        end
        if (!ok) chk("a_send_timeout", {71'd0, ok}, 72'd1);
    endtask

    task automatic send_b(input logic [7:0] v);
        logic ok; int g;
        ok = 1'b0; g = 0;
        b_pv = 1'b1; b_pd = v;
        while (!ok && g < 64) begin
            @(negedge clk); ok = b_pr;
            @(posedge clk); #1; g++;
        end
        if (!ok) chk("b_send_timeout", {71'd0, ok}, 72'd1);
    endtask

    task automatic send_c(input logic [7:0] v);
        logic ok; int g;
        if ($urandom_range(0, 3) == 0) begin
            c_pv = 1'b0;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        ok = 1'b0; g = 0;
        c_pv = 1'b1; c_pd = v;
        while (!ok && g < 64) begin
            @(negedge clk); ok = c_pr;
            @(posedge clk); #1; g++;
        end
        if (!ok) chk("c_send_timeout", {71'd0, ok}, 72'd1);
    endtask

    task automatic drain_a();
        int g;
        g = 0;
        a_pv = 1'b0;
        while (a_wv && g < 40) begin @(posedge clk); #1; g++; end
        chk("a_drain", {71'd0, a_wv}, 72'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_a_frame(input string tag, input int base);
        chk({tag, "_count"}, qa.size(), 72'd4);
        for (int i = 0; i < qa.size() && i < 4; i++)
            chk({tag, "_win"}, qa[i], win4(base + (i / 2) * 4 + (i % 2)));
    endtask

    logic [7:0]  fr [2][784];
    logic [71:0] expq[$];

    initial begin
        int g;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);
        chk("rst_win_valid", {71'd0, a_wv}, 72'd0);
        chk("rst_pix_ready", {71'd0, a_pr}, 72'd1);
        chk("rst_window", a_win, 72'd0);
        chk("rst_frame_done", {71'd0, a_fd}, 72'd0);
        @(posedge clk); #1;

        // 4x4 frame, downstream always ready
        qa.delete(); a_fd_cnt = 0;
        for (int i = 0; i < 16; i++) send_a(8'(i));
        drain_a();
        check_a_frame("basic", 0);
        chk("basic_first", qa[0], w3(0, 1, 2, 4, 5, 6, 8, 9, 10));
        chk("basic_last", qa[3], w3(5, 6, 7, 9, 10, 11, 13, 14, 15));
        chk("basic_fd_cnt", a_fd_cnt, 72'd1);

        // Same frame with three stall cycles per window
        qa.delete(); a_fd_cnt = 0; a_mode = 1;
        for (int i = 0; i < 16; i++) send_a(8'(i));
        drain_a();
        a_mode = 0;
        check_a_frame("stall", 0);
        chk("stall_fd_cnt", a_fd_cnt, 72'd1);

        // Back-to-back frames with no idle cycle
        qa.delete(); a_fd_cnt = 0;
        for (int i = 0; i < 16; i++) send_a(8'(i));
        for (int i = 0; i < 16; i++) send_a(8'(100 + i));
        drain_a();
        chk("b2b_count", qa.size(), 72'd8);
        if (qa.size() == 8) begin
            chk("b2b_fifth", qa[4], w3(100, 101, 102, 104, 105, 106, 108, 109, 110));
            for (int i = 0; i < 8; i++)
                chk("b2b_win", qa[i], win4((i < 4 ? 0 : 100) + ((i % 4) / 2) * 4 + (i % 2)));
        end
        chk("b2b_fd_cnt", a_fd_cnt, 72'd2);

        // Reset mid-frame after pixel 9
        qa.delete(); a_fd_cnt = 0;
        for (int i = 0; i < 10; i++) send_a(8'(i));
        a_pv = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        a_rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        a_rst = 1'b0;
        @(negedge clk);
        chk("midrst_count", qa.size(), 72'd0);
        chk("midrst_win_valid", {71'd0, a_wv}, 72'd0);
        chk("midrst_pix_ready", {71'd0, a_pr}, 72'd1);
        chk("midrst_window", a_win, 72'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send_a(8'(i));
        drain_a();
        check_a_frame("midrst", 0);
        chk("midrst_fd_cnt", a_fd_cnt, 72'd1);

        // 5x3 frame of alternating extremes
        qb.delete(); b_fd_cnt = 0;
        for (int i = 0; i < 15; i++) send_b((i % 2 == 0) ? 8'h80 : 8'h7f);
        b_pv = 1'b0;
        g = 0;
        while (b_wv && g < 40) begin @(posedge clk); #1; g++; end
        repeat (3) begin @(posedge clk); #1; end
        chk("signed_count", qb.size(), 72'd3);
        if (qb.size() == 3) begin
            chk("signed_w0", qb[0], w3(-128, 127, -128, 127, -128, 127, -128, 127, -128));
            chk("signed_w1", qb[1], w3(127, -128, 127, -128, 127, -128, 127, -128, 127));
            chk("signed_w2", qb[2], w3(-128, 127, -128, 127, -128, 127, -128, 127, -128));
        end
        chk("signed_fd_cnt", b_fd_cnt, 72'd1);

        // Two 28x28 frames with random valid gaps and random downstream ready
        qc.delete(); expq.delete(); c_fd_cnt = 0; c_rnd = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 784; p++) fr[f][p] = 8'($urandom_range(0, 255));
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 26; r++)
                for (int c = 0; c < 26; c++) begin
                    logic [71:0] w;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            w[(i*3 + j)*8 +: 8] = fr[f][(r + i)*28 + c + j];
                    expq.push_back(w);
                end
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 784; p++) send_c(fr[f][p]);
        c_pv = 1'b0;
        g = 0;
        while (c_wv && g < 200) begin @(posedge clk); #1; g++; end
        chk("rand_drain", {71'd0, c_wv}, 72'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("rand_count", qc.size(), 72'd1352);
        chk("rand_fd_cnt", c_fd_cnt, 72'd2);
        for (int i = 0; i < qc.size() && i < expq.size(); i++)
            chk("rand_win", qc[i], expq[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
